// File: rtl/mul_booth_r4_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier.
package mul_booth_r4_pkg;

  // Operation codes. 2'b11 is decoded as a plain multiply.
  localparam logic [1:0] MUL_OP_MUL  = 2'b00;
  localparam logic [1:0] MUL_OP_MADD = 2'b01;
  localparam logic [1:0] MUL_OP_MSUB = 2'b10;

  // Control FSM states.
  typedef enum logic [1:0] {
    MUL_ST_IDLE = 2'b00,
    MUL_ST_CALC = 2'b01,
    MUL_ST_ACC  = 2'b10,
    MUL_ST_DONE = 2'b11
  } mul_state_e;

  // Booth recoding of one 3-bit multiplier group into a signed digit selector.
  typedef enum logic [2:0] {
    BSEL_ZERO = 3'd0,
    BSEL_P1   = 3'd1,
    BSEL_P2   = 3'd2,
    BSEL_M1   = 3'd3,
    BSEL_M2   = 3'd4
  } booth_sel_e;

  function automatic booth_sel_e booth_decode(input logic [2:0] grp);
    booth_sel_e s;
    unique case (grp)
      3'b001, 3'b010: s = BSEL_P1;
      3'b011:         s = BSEL_P2;
      3'b100:         s = BSEL_M2;
      3'b101, 3'b110: s = BSEL_M1;
      default:        s = BSEL_ZERO;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/booth_r4_sel.sv
// Radix-4 Booth partial-product selector: picks 0, +-M or +-2M for one group.
module booth_r4_sel
  import mul_booth_r4_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       grp_i,
  input  logic [WIDTH+1:0] mcand_i,
  output logic [WIDTH+2:0] pp_o
);

  logic [WIDTH+2:0] m1;
  logic [WIDTH+2:0] m2;

  assign m1 = {mcand_i[WIDTH+1], mcand_i};
  assign m2 = {mcand_i, 1'b0};

  // Partial product for the decoded Booth digit, one bit wider than M to hold 2M.
  always_comb begin
    pp_o = '0;
    unique case (booth_decode(grp_i))
      BSEL_P1: pp_o = m1;
      BSEL_P2: pp_o = m2;
      BSEL_M1: pp_o = -m1;
      BSEL_M2: pp_o = -m2;
      default: pp_o = '0;
    endcase
  end

endmodule

// File: rtl/mul_booth_r4.sv
// Iterative radix-4 Booth multiplier with MADD/MSUB accumulate, valid/ready issue,
// one-cycle done pulse and flush abort.
module mul_booth_r4
  import mul_booth_r4_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid,
  output logic                 ready,
  input  logic                 flag_unsigned,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     mul1,
  input  logic [WIDTH-1:0]     mul2,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic                 flush,
  output logic [2*WIDTH-1:0]   result,
  output logic                 done,
  output logic                 busy
);

  localparam int ITER = (WIDTH + 2) / 2;
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER);

  mul_state_e          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WIDTH+1:0]    mcand_q, mcand_d;   // extended multiplicand M
  logic [WIDTH+2:0]    hi_q, hi_d;         // running upper half of the product
  logic [WIDTH+1:0]    lo_q, lo_d;         // multiplier, refilled with product bits
  logic                bm1_q, bm1_d;       // b[2i-1] for the next group
  logic [2*WIDTH-1:0]  acc_q, acc_d;
  logic [1:0]          op_q, op_d;
  logic [2*WIDTH-1:0]  p_q, p_d;           // finished product handed to the ACC adder
  logic [2*WIDTH-1:0]  result_q, result_d;

  logic                accept;
  logic [2:0]          grp;
  logic [WIDTH+2:0]    pp;
  logic [WIDTH+2:0]    sum;
  logic [2*WIDTH-1:0]  prod;

  assign ready  = ((state_q == MUL_ST_IDLE) || (state_q == MUL_ST_DONE)) & ~flush;
  assign busy   = (state_q == MUL_ST_CALC) || (state_q == MUL_ST_ACC);
  assign done   = (state_q == MUL_ST_DONE);
  assign result = result_q;
  assign accept = valid & ready;

  assign grp  = {lo_q[1:0], bm1_q};
  assign sum  = hi_q + pp;
  assign prod = {hi_q[WIDTH-3:0], lo_q};

  booth_r4_sel #(.WIDTH(WIDTH)) u_sel (
    .grp_i   (grp),
    .mcand_i (mcand_q),
    .pp_o    (pp)
  );

  // Next-state and datapath: accept/load, Booth step, product hand-off, accumulate.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    bm1_d    = bm1_q;
    acc_d    = acc_q;
    op_d     = op_q;
    p_d      = p_q;
    result_d = result_q;
    unique case (state_q)
      MUL_ST_IDLE, MUL_ST_DONE: begin
        if (accept) begin
          // Two extra bits keep unsigned operands positive under Booth recoding.
          mcand_d = flag_unsigned ? {2'b00, mul1} : {{2{mul1[WIDTH-1]}}, mul1};
          lo_d    = flag_unsigned ? {2'b00, mul2} : {{2{mul2[WIDTH-1]}}, mul2};
          hi_d    = '0;
          bm1_d   = 1'b0;
          cnt_d   = '0;
          acc_d   = acc;
          op_d    = op;
          state_d = MUL_ST_CALC;
        end else begin
          state_d = MUL_ST_IDLE;
        end
      end
      MUL_ST_CALC: begin
        if (flush) begin
          state_d = MUL_ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          // Register the product so the wide ACC adder starts from a flop.
          p_d     = prod;
          state_d = MUL_ST_ACC;
        end else begin
          hi_d  = {{2{sum[WIDTH+2]}}, sum[WIDTH+2:2]};
          lo_d  = {sum[1:0], lo_q[WIDTH+1:2]};
          bm1_d = lo_q[1];
          cnt_d = cnt_q + 1'b1;
        end
      end
      MUL_ST_ACC: begin
        if (flush) begin
          state_d = MUL_ST_IDLE;
        end else begin
          unique case (op_q)
            MUL_OP_MADD: result_d = acc_q + p_q;
            MUL_OP_MSUB: result_d = acc_q - p_q;
            default:     result_d = p_q;
          endcase
          state_d = MUL_ST_DONE;
        end
      end
      default: state_d = MUL_ST_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything, aborting any op.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= MUL_ST_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      bm1_q    <= 1'b0;
      acc_q    <= '0;
      op_q     <= '0;
      p_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      bm1_q    <= bm1_d;
      acc_q    <= acc_d;
      op_q     <= op_d;
      p_q      <= p_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_mul_booth_r4.sv
// Scoreboard bench for mul_booth_r4: driver pushes expected results on accept,
// monitor pops and checks value and latency on every done pulse.
module tb_mul_booth_r4;

  localparam int W   = 32;
  localparam int LAT = 19;

  logic            clk;
  logic            rst_n;
  logic            valid;
  logic            ready;
  logic            flag_unsigned;
  logic [1:0]      op;
  logic [W-1:0]    mul1;
  logic [W-1:0]    mul2;
  logic [2*W-1:0]  acc;
  logic            flush;
  logic [2*W-1:0]  result;
  logic            done;
  logic            busy;

  typedef struct {
    logic [63:0] res;
    int          acc_edge;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          ecnt   = 0;
  logic [63:0] last_res = '0;

  mul_booth_r4 #(.WIDTH(W)) dut (
    .clk           (clk),
    .reset         (rst_n),
    .valid         (valid),
    .ready         (ready),
    .flag_unsigned (flag_unsigned),
    .op            (op),
    .mul1          (mul1),
    .mul2          (mul2),
    .acc           (acc),
    .flush         (flush),
    .result        (result),
    .done          (done),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  // Reference: extend, multiply in 64-bit modular arithmetic, then accumulate.
  function automatic logic [63:0] model(input bit u, input logic [1:0] o,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic [63:0] ac);
    logic [63:0] ea, eb, p;
    ea = u ? {32'b0, a} : {{32{a[31]}}, a};
    eb = u ? {32'b0, b} : {{32{b[31]}}, b};
    p  = ea * eb;
    case (o)
      2'b01:   return ac + p;
      2'b10:   return ac - p;
      default: return p;
    endcase
  endfunction

  // Monitor: every done must match the oldest expected op and arrive LAT edges after accept.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done: got done=1 expected no pending op (edge %0d)", ecnt);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", result, e.res);
          chk("latency", 64'(ecnt - e.acc_edge), 64'(LAT));
          if (!flush) chk("ready_in_done", {63'b0, ready}, 64'd1);
          last_res = e.res;
        end
      end else begin
        chk("result_hold", result, last_res);
      end
    end
  end

  // Callers enter and leave tasks 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit u, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] ac);
    int tries;
    exp_t e;
    tries = 0;
    valid = 1'b1; flag_unsigned = u; op = o; mul1 = a; mul2 = b; acc = ac;
    forever begin
      @(negedge clk);
      if (ready) begin
        e.res      = model(u, o, a, b, ac);
        e.acc_edge = ecnt + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        valid = 1'b0;
        mul1 = $urandom; mul2 = $urandom; acc = {$urandom, $urandom};
        return;
      end
      tries++;
      if (tries > 100) begin
        checks++;
        errors++;
        $display("FAIL issue_timeout: got ready=0 for 100 cycles expected ready=1");
        @(posedge clk);
        #1;
        valid = 1'b0;
        return;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      step(1);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending ops expected 0", sb.size());
      sb.delete();
    end
    step(2);
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; flush = 1'b0; flag_unsigned = 1'b0;
    op = 2'b00; mul1 = '0; mul2 = '0; acc = '0;

    // Reset state
    step(3);
    @(negedge clk);
    chk("rst_result", result, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_ready", {63'b0, ready}, 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1);

    // Directed products, issued back to back
    issue(1'b1, 2'b00, 32'd10, 32'd20, 64'd0);
    issue(1'b0, 2'b00, -32'd888, 32'd666, 64'd0);
    issue(1'b0, 2'b00, -32'd777700, -32'd666600, 64'd0);
    issue(1'b1, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0);
    issue(1'b0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0);
    issue(1'b0, 2'b10, 32'd3, -32'd5, 64'd100);
    issue(1'b1, 2'b01, 32'd1, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(1'b1, 2'b11, 32'h80000000, 32'h80000000, 64'd55);
    issue(1'b0, 2'b00, 32'h80000000, 32'h7FFFFFFF, 64'd0);
    drain();

    // Flush on the 5th CALC cycle: op dropped, result held
    issue(1'b1, 2'b00, 32'd1234, 32'd5678, 64'd0);
    step(4);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("flush_ready", {63'b0, ready}, 64'd1);
    chk("flush_busy", {63'b0, busy}, 64'd0);
    step(25);
    issue(1'b1, 2'b00, 32'd7, 32'd6, 64'd0);
    drain();

    // valid and flush together in IDLE: nothing is accepted
    valid = 1'b1; flush = 1'b1; op = 2'b00; mul1 = 32'd9; mul2 = 32'd9;
    @(negedge clk);
    chk("vf_ready", {63'b0, ready}, 64'd0);
    step(1);
    valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("vf_busy", {63'b0, busy}, 64'd0);
    step(25);

    // Asynchronous reset in the middle of CALC
    issue(1'b0, 2'b01, 32'd77, 32'd88, 64'd5);
    step(6);
    rst_n = 1'b0;
    #1;
    chk("arst_result", result, 64'd0);
    chk("arst_done", {63'b0, done}, 64'd0);
    chk("arst_busy", {63'b0, busy}, 64'd0);
    sb.delete();
    last_res = '0;
    step(2);
    rst_n = 1'b1;
    step(1);
    issue(1'b1, 2'b00, 32'd2, 32'd3, 64'd0);
    drain();

    // Random ops with corner operands and random gaps
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 32'hFFFFFFFF : 32'h80000000) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 32'h7FFFFFFF : 32'h00000000) : $urandom;
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, b, {$urandom, $urandom});
      if ($urandom_range(0, 2) == 0) step($urandom_range(1, 3));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
